// File: rtl/logic_slice_sched_if.sv
// Bus bundle for logic_slice_sched: two request channels, the shared
// slice connection and the response channel. The slave modport is the
// scheduler's view; the master modport is the requesters' and consumer's
// view, and it also drives the external combinational slice result.
interface logic_slice_sched_if #(
  parameter int DATA_W  = 32,
  parameter int SLICE_W = 4
);
  logic                req0_valid;
  logic                req0_ready;
  logic [1:0]          req0_op;
  logic [DATA_W-1:0]   req0_a;
  logic [DATA_W-1:0]   req0_b;

  logic                req1_valid;
  logic                req1_ready;
  logic [1:0]          req1_op;
  logic [DATA_W-1:0]   req1_a;
  logic [DATA_W-1:0]   req1_b;

  logic [1:0]          slice_op;
  logic [SLICE_W-1:0]  slice_a;
  logic [SLICE_W-1:0]  slice_b;
  logic [SLICE_W-1:0]  slice_result;

  logic                resp_valid;
  logic                resp_ready;
  logic                resp_id;
  logic [DATA_W-1:0]   resp_result;
  logic                busy;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req1_ready,
    input  slice_op, slice_a, slice_b,
    output slice_result,
    input  resp_valid, resp_id, resp_result, busy,
    output resp_ready
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req1_ready,
    output slice_op, slice_a, slice_b,
    input  slice_result,
    output resp_valid, resp_id, resp_result, busy,
    input  resp_ready
  );
endinterface

// File: rtl/logic_slice_sched.sv
// Two-requester scheduler for one shared SLICE_W-bit bitwise logic slice.
// An accepted operation is walked LSB-first through the slice, one slice
// per cycle, and the assembled DATA_W-bit result is offered on a
// valid/ready response channel. Grants alternate when both requesters wait.
module logic_slice_sched #(
  parameter int DATA_W  = 32,
  parameter int SLICE_W = 4
) (
  input logic                clk,
  input logic                rst_n,
  logic_slice_sched_if.slave bus
);

  localparam int NSLICE = DATA_W / SLICE_W;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  logic [1:0]         r_state;
  logic [IDX_W-1:0]   r_idx;
  logic               r_last;
  logic               r_id;
  logic [1:0]         r_op;
  logic [DATA_W-1:0]  r_a;
  logic [DATA_W-1:0]  r_b;
  logic [DATA_W-1:0]  r_res;

  logic               w_idle;
  logic               w_run;
  logic               w_done;
  logic               w_any;
  logic               w_gnt;
  logic               w_accept;
  logic               w_last_idx;
  logic [SLICE_W-1:0] w_sa;
  logic [SLICE_W-1:0] w_sb;

  assign w_idle     = (r_state == S_IDLE);
  assign w_run      = (r_state == S_RUN);
  assign w_done     = (r_state == S_DONE);
  assign w_any      = bus.req0_valid | bus.req1_valid;
  // With both requesters waiting, serve the one not served last time.
  assign w_gnt      = (bus.req0_valid && bus.req1_valid) ? ~r_last : bus.req1_valid;
  assign w_accept   = w_idle & w_any;
  assign w_last_idx = (r_idx == IDX_W'(NSLICE - 1));

  // rst_n gating keeps both readys low while reset is held, even if a
  // requester is already presenting valid.
  assign bus.req0_ready = rst_n & w_accept & ~w_gnt;
  assign bus.req1_ready = rst_n & w_accept &  w_gnt;

  // Select the current operand slices; constant part-select bases keep the
  // index compare explicit.
  always_comb begin
    w_sa = '0;
    w_sb = '0;
    for (int s = 0; s < NSLICE; s++) begin
      if (r_idx == IDX_W'(s)) begin
        w_sa = r_a[s*SLICE_W +: SLICE_W];
        w_sb = r_b[s*SLICE_W +: SLICE_W];
      end
    end
  end

  // The slice is only driven while an operation is running.
  assign bus.slice_op    = w_run ? r_op : 2'b00;
  assign bus.slice_a     = w_run ? w_sa : '0;
  assign bus.slice_b     = w_run ? w_sb : '0;

  // resp_result follows the result register, so the last answer stays
  // visible in IDLE until the next acceptance clears it.
  assign bus.resp_valid  = w_done;
  assign bus.resp_id     = w_done & r_id;
  assign bus.resp_result = r_res;
  assign bus.busy        = w_run | w_done;

  // Control FSM: state, slice index and fairness memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_last  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_RUN;
            r_idx   <= '0;
            r_last  <= w_gnt;
          end
        end
        S_RUN: begin
          if (w_last_idx) begin
            r_state <= S_DONE;
            r_idx   <= '0;
          end else begin
            r_idx   <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          if (bus.resp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_idx   <= '0;
        end
      endcase
    end
  end

  // Operand capture at acceptance and per-slice assembly of the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op  <= 2'b00;
      r_a   <= '0;
      r_b   <= '0;
      r_id  <= 1'b0;
      r_res <= '0;
    end else if (w_accept) begin
      r_op  <= w_gnt ? bus.req1_op : bus.req0_op;
      r_a   <= w_gnt ? bus.req1_a  : bus.req0_a;
      r_b   <= w_gnt ? bus.req1_b  : bus.req0_b;
      r_id  <= w_gnt;
      r_res <= '0;
    end else if (w_run) begin
      for (int s = 0; s < NSLICE; s++) begin
        if (r_idx == IDX_W'(s)) begin
          r_res[s*SLICE_W +: SLICE_W] <= bus.slice_result;
        end
      end
    end
  end

endmodule

// File: tb/tb_logic_slice_sched.sv
// Self-checking bench for logic_slice_sched: models the external logic
// slice, drives both requesters and checks responses against a full-width
// bitwise reference and an alternating-grant fairness model.
module tb_logic_slice_sched;

  localparam int DATA_W  = 32;
  localparam int SLICE_W = 4;
  localparam int NSLICE  = DATA_W / SLICE_W;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  logic_slice_sched_if #(.DATA_W(DATA_W), .SLICE_W(SLICE_W)) bus ();

  logic_slice_sched #(.DATA_W(DATA_W), .SLICE_W(SLICE_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External combinational logic slice.
  always_comb begin
    bus.slice_result = '0;
    case (bus.slice_op)
      2'b00: bus.slice_result = bus.slice_a & bus.slice_b;
      2'b01: bus.slice_result = bus.slice_a | bus.slice_b;
      2'b10: bus.slice_result = bus.slice_a ^ bus.slice_b;
      2'b11: bus.slice_result = ~(bus.slice_a | bus.slice_b);
      default: bus.slice_result = '0;
    endcase
  end

  // Full-width reference for one operation.
  function automatic logic [DATA_W-1:0] ref_op(input logic [1:0] op,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_op = 2'b00; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_op = 2'b00; bus.req1_a = '0; bus.req1_b = '0;
    bus.resp_ready = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    #1;
  endtask

  // Steps until resp_valid (bounded); records readys seen and busy drops.
  task automatic wait_resp(output int n, output bit rdy_seen, output bit busy_low);
    n = 0; rdy_seen = 1'b0; busy_low = 1'b0;
    while (bus.resp_valid !== 1'b1 && n < 4*NSLICE) begin
      if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) rdy_seen = 1'b1;
      if (bus.busy !== 1'b1) busy_low = 1'b1;
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    logic [DATA_W+12:0] outs;
    idle_inputs();
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    outs = {bus.req0_ready, bus.req1_ready, bus.resp_valid, bus.resp_id, bus.busy,
            bus.slice_op, bus.slice_a, bus.slice_b, bus.resp_result};
    n_checks++;
    if (outs !== '0) $display("FAIL reset_outputs: got %h expected 0", outs);
    else n_pass++;
    step();
    n_checks++;
    if (bus.busy !== 1'b0 || bus.req0_ready !== 1'b0)
      $display("FAIL reset_held: busy=%b req0_ready=%b expected 0/0", bus.busy, bus.req0_ready);
    else n_pass++;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if ({bus.req1_ready, bus.req0_ready} !== 2'b01)
      $display("FAIL reset_first_grant: got %b expected 01", {bus.req1_ready, bus.req0_ready});
    else n_pass++;
    idle_inputs();
    step();
    n_checks++;
    if (bus.busy !== 1'b0) $display("FAIL reset_no_accept: busy=%b expected 0", bus.busy);
    else n_pass++;
  endtask

  task automatic test_single();
    int n; bit rs, bl;
    logic [DATA_W-1:0] exp_res;
    apply_reset();
    bus.req0_op = 2'b11; bus.req0_a = 32'h0F0F_0000; bus.req0_b = 32'h00FF_0000;
    bus.req0_valid = 1'b1;
    exp_res = ref_op(2'b11, 32'h0F0F_0000, 32'h00FF_0000);
    #1;
    n_checks++;
    if (bus.req0_ready !== 1'b1) $display("FAIL single_ready: got %b expected 1", bus.req0_ready);
    else n_pass++;
    step();
    bus.req0_valid = 1'b0;
    wait_resp(n, rs, bl);
    n_checks++;
    if (n !== NSLICE) $display("FAIL single_latency: got %0d expected %0d", n, NSLICE);
    else n_pass++;
    n_checks++;
    if (bl !== 1'b0) $display("FAIL single_busy: busy dropped=%b expected 0", bl);
    else n_pass++;
    n_checks++;
    if (bus.resp_id !== 1'b0 || bus.resp_result !== exp_res || bus.busy !== 1'b1)
      $display("FAIL single_result: id=%b res=%h busy=%b expected 0 %h 1",
               bus.resp_id, bus.resp_result, bus.busy, exp_res);
    else n_pass++;
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.resp_valid !== 1'b0)
      $display("FAIL single_release: busy=%b resp_valid=%b expected 0/0", bus.busy, bus.resp_valid);
    else n_pass++;
  endtask

  task automatic test_both();
    int n; bit rs, bl;
    apply_reset();
    bus.req0_op = 2'b00; bus.req0_a = 32'hFFFF_0000; bus.req0_b = 32'h0F0F_0F0F;
    bus.req1_op = 2'b10; bus.req1_a = 32'hAAAA_AAAA; bus.req1_b = 32'hFFFF_FFFF;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    #1;
    n_checks++;
    if ({bus.req1_ready, bus.req0_ready} !== 2'b01)
      $display("FAIL both_grant0: got %b expected 01", {bus.req1_ready, bus.req0_ready});
    else n_pass++;
    step();
    bus.req0_valid = 1'b0;
    wait_resp(n, rs, bl);
    n_checks++;
    if (rs !== 1'b0 || bus.req1_ready !== 1'b0)
      $display("FAIL both_req1_blocked: ready seen=%b now=%b expected 0", rs, bus.req1_ready);
    else n_pass++;
    n_checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_id !== 1'b0 || bus.resp_result !== 32'h0F0F_0000)
      $display("FAIL both_resp0: v=%b id=%b res=%h expected 1 0 0f0f0000",
               bus.resp_valid, bus.resp_id, bus.resp_result);
    else n_pass++;
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
    n_checks++;
    if (bus.req1_ready !== 1'b1) $display("FAIL both_grant1: got %b expected 1", bus.req1_ready);
    else n_pass++;
    step();
    bus.req1_valid = 1'b0;
    wait_resp(n, rs, bl);
    n_checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_id !== 1'b1 || bus.resp_result !== 32'h5555_5555)
      $display("FAIL both_resp1: v=%b id=%b res=%h expected 1 1 55555555",
               bus.resp_valid, bus.resp_id, bus.resp_result);
    else n_pass++;
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_fairness();
    logic [1:0]        p_op [2];
    logic [DATA_W-1:0] p_a  [2];
    logic [DATA_W-1:0] p_b  [2];
    logic              last, g;
    logic [DATA_W-1:0] exp_res;
    int n, acc, prev_acc;
    bit rs, bl;
    apply_reset();
    last = 1'b1;
    prev_acc = 0;
    for (int r = 0; r < 2; r++) begin
      p_op[r] = 2'($urandom); p_a[r] = $urandom; p_b[r] = $urandom;
    end
    bus.req0_op = p_op[0]; bus.req0_a = p_a[0]; bus.req0_b = p_b[0];
    bus.req1_op = p_op[1]; bus.req1_a = p_a[1]; bus.req1_b = p_b[1];
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    bus.resp_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      #1;
      g = ~last;
      n_checks++;
      if ({bus.req1_ready, bus.req0_ready} !== (g ? 2'b10 : 2'b01))
        $display("FAIL fair_grant[%0d]: got %b expected id %b", t,
                 {bus.req1_ready, bus.req0_ready}, g);
      else n_pass++;
      exp_res = ref_op(p_op[g], p_a[g], p_b[g]);
      step();
      acc = cyc;
      if (t > 0) begin
        n_checks++;
        if (acc - prev_acc !== NSLICE + 2)
          $display("FAIL fair_interval[%0d]: got %0d expected %0d", t, acc - prev_acc, NSLICE + 2);
        else n_pass++;
      end
      prev_acc = acc;
      last = g;
      p_op[g] = 2'($urandom); p_a[g] = $urandom; p_b[g] = $urandom;
      if (g) begin
        bus.req1_op = p_op[1]; bus.req1_a = p_a[1]; bus.req1_b = p_b[1];
      end else begin
        bus.req0_op = p_op[0]; bus.req0_a = p_a[0]; bus.req0_b = p_b[0];
      end
      wait_resp(n, rs, bl);
      n_checks++;
      if (n !== NSLICE || rs !== 1'b0 || bus.resp_id !== g || bus.resp_result !== exp_res)
        $display("FAIL fair_resp[%0d]: lat=%0d rdy=%b id=%b res=%h expected %0d 0 %b %h",
                 t, n, rs, bus.resp_id, bus.resp_result, NSLICE, g, exp_res);
      else n_pass++;
      step();
    end
    idle_inputs();
    step();
  endtask

  task automatic test_backpressure();
    int n; bit rs, bl;
    logic [DATA_W-1:0] exp_res;
    logic [DATA_W+12:0] got, want;
    idle_inputs();
    bus.req0_op = 2'($urandom); bus.req0_a = $urandom; bus.req0_b = $urandom;
    exp_res = ref_op(bus.req0_op, bus.req0_a, bus.req0_b);
    bus.req0_valid = 1'b1;
    #1;
    step();
    bus.req0_valid = 1'b0;
    wait_resp(n, rs, bl);
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.req1_op = 2'($urandom); bus.req1_a = $urandom; bus.req1_b = $urandom;
    want = {1'b1, 1'b0, exp_res, 1'b0, 1'b0, 2'b00, {SLICE_W{1'b0}}, {SLICE_W{1'b0}}};
    for (int i = 0; i < 6; i++) begin
      #1;
      got = {bus.resp_valid, bus.resp_id, bus.resp_result, bus.req0_ready, bus.req1_ready,
             bus.slice_op, bus.slice_a, bus.slice_b};
      n_checks++;
      if (got !== want) $display("FAIL bp_hold[%0d]: got %h expected %h", i, got, want);
      else n_pass++;
      if (i == 5) bus.resp_ready = 1'b1;
      step();
    end
    bus.resp_ready = 1'b0;
    n_checks++;
    if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0 || {bus.req1_ready, bus.req0_ready} !== 2'b10)
      $display("FAIL bp_idle: v=%b busy=%b rdy=%b expected 0 0 10",
               bus.resp_valid, bus.busy, {bus.req1_ready, bus.req0_ready});
    else n_pass++;
    n_checks++;
    if (bus.resp_result !== exp_res)
      $display("FAIL bp_result_kept: got %h expected %h", bus.resp_result, exp_res);
    else n_pass++;
    idle_inputs();
    step();
  endtask

  task automatic test_slice_order();
    logic [DATA_W-1:0] a;
    logic [SLICE_W+SLICE_W+1:0] got, want;
    idle_inputs();
    a = 32'h7654_3210;
    bus.req1_op = 2'b01; bus.req1_a = a; bus.req1_b = '0;
    bus.req1_valid = 1'b1;
    #1;
    n_checks++;
    if (bus.req1_ready !== 1'b1) $display("FAIL order_ready: got %b expected 1", bus.req1_ready);
    else n_pass++;
    step();
    bus.req1_valid = 1'b0;
    n_checks++;
    if (bus.resp_result !== '0)
      $display("FAIL accept_clears_result: got %h expected 0", bus.resp_result);
    else n_pass++;
    for (int i = 0; i < NSLICE; i++) begin
      want = {2'b01, SLICE_W'(a >> (SLICE_W*i)), {SLICE_W{1'b0}}};
      got  = {bus.slice_op, bus.slice_a, bus.slice_b};
      n_checks++;
      if (got !== want) $display("FAIL order_slice[%0d]: got %h expected %h", i, got, want);
      else n_pass++;
      step();
    end
    n_checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_id !== 1'b1 || bus.resp_result !== a)
      $display("FAIL order_resp: v=%b id=%b res=%h expected 1 1 %h",
               bus.resp_valid, bus.resp_id, bus.resp_result, a);
    else n_pass++;
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int n; bit rs, bl, seen;
    logic [DATA_W+12:0] outs;
    idle_inputs();
    bus.req0_op = 2'b10; bus.req0_a = $urandom; bus.req0_b = $urandom;
    bus.req0_valid = 1'b1;
    #1;
    step();
    bus.req0_valid = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    outs = {bus.req0_ready, bus.req1_ready, bus.resp_valid, bus.resp_id, bus.busy,
            bus.slice_op, bus.slice_a, bus.slice_b, bus.resp_result};
    n_checks++;
    if (outs !== '0) $display("FAIL midrun_reset_outputs: got %h expected 0", outs);
    else n_pass++;
    step();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < NSLICE + 2; i++) begin
      if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
      step();
    end
    n_checks++;
    if (seen !== 1'b0) $display("FAIL midrun_no_resp: activity=%b expected 0", seen);
    else n_pass++;
    rst_n = 1'b0;
    step();
    bus.req0_op = 2'b01; bus.req0_a = 32'h1234_5678; bus.req0_b = 32'h8765_4321;
    bus.req0_valid = 1'b1;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus.req0_ready !== 1'b1) $display("FAIL midrun_ready_after_release: got %b expected 1", bus.req0_ready);
    else n_pass++;
    step();
    bus.req0_valid = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b1) $display("FAIL midrun_first_accept: busy=%b expected 1", bus.busy);
    else n_pass++;
    wait_resp(n, rs, bl);
    n_checks++;
    if (n !== NSLICE || bus.resp_id !== 1'b0 || bus.resp_result !== 32'h9775_5779)
      $display("FAIL midrun_resp: lat=%0d id=%b res=%h expected %0d 0 97755779",
               n, bus.resp_id, bus.resp_result, NSLICE);
    else n_pass++;
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_single();
    test_both();
    test_fairness();
    test_backpressure();
    test_slice_order();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
